// File: rtl/reset_conditioner_pkg.sv
// Shared types and defaults for the board reset conditioner.
// Timing constants assume a 48 MHz system clock.
package reset_conditioner_pkg;

  typedef enum logic [1:0] {
    EXT_HOLD,
    STRETCH,
    RUN
  } state_t;

  localparam int DEF_DEBOUNCE = 480;
  localparam int DEF_STRETCH  = 4800;

  // Counter width able to hold max(deb, str) - 1.
  function automatic int min_cnt_w(input int deb, input int str);
    int m;
    m = (deb > str) ? deb : str;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/reset_conditioner_if.sv
// External reset request in, conditioned system reset out.
// master = conditioner side, slave = consumer/driver side.
interface reset_conditioner_if #(
  parameter int EVT_W = 8
) ();

  logic             EXT_RESET;
  logic             SYS_RESET;
  logic             SYS_READY;
  logic             EXT_LEVEL;
  logic [EVT_W-1:0] RESET_COUNT;

  modport master (
    input  EXT_RESET,
    output SYS_RESET,
    output SYS_READY,
    output EXT_LEVEL,
    output RESET_COUNT
  );

  modport slave (
    output EXT_RESET,
    input  SYS_RESET,
    input  SYS_READY,
    input  EXT_LEVEL,
    input  RESET_COUNT
  );

endinterface

// File: rtl/reset_conditioner_sync_debounce.sv
// Synchroniser and level debouncer for the raw EXT_RESET pin.
// Emits the accepted level plus a one-cycle strobe on each 1->0 change.
module reset_sync_debounce
  import reset_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ext_reset,
  output logic ext_level,
  output logic fall_stb
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       deb_cnt;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift the async pin through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_reset};
    end
  end

  // Accept a new level only after it has been stable long enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_level <= 1'b1;
      deb_cnt   <= '0;
      fall_stb  <= 1'b0;
    end else begin
      fall_stb <= 1'b0;
      if (s != ext_level) begin
        if (deb_cnt == DEB_LAST) begin
          ext_level <= s;
          deb_cnt   <= '0;
          fall_stb  <= ~s;
        end else begin
          deb_cnt <= deb_cnt + CNT_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/reset_conditioner.sv
// Board reset conditioner: debounced external request, stretched
// synchronous release, ready pulse and saturating event count.
module reset_conditioner
  import reset_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int STRETCH_CYCLES  = DEF_STRETCH,
  parameter int CNT_W           = 16,
  parameter int EVT_W           = 8
) (
  input  logic                CLK_48MHZ,
  input  logic                RESET,
  reset_conditioner_if.master bus
);

  localparam logic [CNT_W-1:0] STR_LAST = CNT_W'(STRETCH_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] str_cnt;
  logic             sys_reset;
  logic             sys_ready;
  logic [EVT_W-1:0] evt_cnt;
  logic             ext_level;
  logic             fall_stb;

  reset_sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_sync_deb (
    .clk      (CLK_48MHZ),
    .rst      (RESET),
    .ext_reset(bus.EXT_RESET),
    .ext_level(ext_level),
    .fall_stb (fall_stb)
  );

  // Hold/stretch/run sequencing; outputs registered from the next state.
  always_ff @(posedge CLK_48MHZ or posedge RESET) begin
    if (RESET) begin
      state     <= STRETCH;
      str_cnt   <= '0;
      sys_reset <= 1'b1;
      sys_ready <= 1'b0;
    end else begin
      sys_reset <= 1'b1;
      sys_ready <= 1'b0;
      unique case (state)
        EXT_HOLD: begin
          str_cnt <= '0;
          if (ext_level) state <= STRETCH;
        end
        STRETCH: begin
          if (!ext_level) begin
            state   <= EXT_HOLD;
            str_cnt <= '0;
          end else if (str_cnt == STR_LAST) begin
            state     <= RUN;
            str_cnt   <= '0;
            sys_reset <= 1'b0;
            sys_ready <= 1'b1;
          end else begin
            str_cnt <= str_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (!ext_level) state <= EXT_HOLD;
          else sys_reset <= 1'b0;
        end
        default: begin
          state   <= STRETCH;
          str_cnt <= '0;
        end
      endcase
    end
  end

  // Count accepted external presses, sticking at all-ones.
  always_ff @(posedge CLK_48MHZ or posedge RESET) begin
    if (RESET) begin
      evt_cnt <= '0;
    end else if (fall_stb && (evt_cnt != '1)) begin
      evt_cnt <= evt_cnt + EVT_W'(1);
    end
  end

  assign bus.SYS_RESET   = sys_reset;
  assign bus.SYS_READY   = sys_ready;
  assign bus.EXT_LEVEL   = ext_level;
  assign bus.RESET_COUNT = evt_cnt;

endmodule

// File: tb/tb_reset_conditioner.sv
// Directed bench for reset_conditioner with short debounce/stretch.
// A second instance with a 2-bit event counter covers saturation.
module tb_reset_conditioner;
  import reset_conditioner_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n;
  int   rdy;
  logic sr_and;
  logic sr_or;
  logic lvl_and;

  always #5 clk = ~clk;

  reset_conditioner_if #(.EVT_W(8)) bus ();
  reset_conditioner_if #(.EVT_W(2)) bus2 ();

  reset_conditioner #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .STRETCH_CYCLES(8), .CNT_W(16), .EVT_W(8)
  ) u_dut (
    .CLK_48MHZ(clk), .RESET(rst), .bus(bus)
  );

  reset_conditioner #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .STRETCH_CYCLES(8), .CNT_W(16), .EVT_W(2)
  ) u_sat (
    .CLK_48MHZ(clk), .RESET(rst), .bus(bus2)
  );

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edges until SYS_RESET reads val; -1 if the budget expires.
  task automatic wait_sys(input logic val, input int budget,
                          output int cnt);
    cnt = -1;
    for (int i = 1; i <= budget; i++) begin
      tick(1);
      if (bus.SYS_RESET === val) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic por();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(10);
  endtask

  initial begin
    rst = 1'b1;
    bus.EXT_RESET  = 1'b1;
    bus2.EXT_RESET = 1'b1;
    tick(5);
    chk("rst_sys_reset", 32'(bus.SYS_RESET), 1);
    chk("rst_sys_ready", 32'(bus.SYS_READY), 0);
    chk("rst_ext_level", 32'(bus.EXT_LEVEL), 1);
    chk("rst_count", 32'(bus.RESET_COUNT), 0);

    // Power-on release: exactly 8 edges.
    rst = 1'b0;
    wait_sys(1'b0, 50, n);
    chk("por_latency", 32'(n), 8);
    chk("por_ready", 32'(bus.SYS_READY), 1);
    chk("por_count", 32'(bus.RESET_COUNT), 0);
    chk("por_level", 32'(bus.EXT_LEVEL), 1);
    tick(1);
    chk("por_ready_drop", 32'(bus.SYS_READY), 0);

    // 3-cycle glitch must be rejected.
    tick(3);
    sr_or   = 1'b0;
    lvl_and = 1'b1;
    bus.EXT_RESET = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) bus.EXT_RESET = 1'b1;
      tick(1);
      sr_or   = sr_or | bus.SYS_RESET;
      lvl_and = lvl_and & bus.EXT_LEVEL;
    end
    chk("glitch_sys_reset", 32'(sr_or), 0);
    chk("glitch_level", 32'(lvl_and), 1);
    chk("glitch_count", 32'(bus.RESET_COUNT), 0);

    // Valid 20-cycle press.
    bus.EXT_RESET = 1'b0;
    wait_sys(1'b1, 50, n);
    chk("press_rise", 32'(n), 7);
    tick(13);
    bus.EXT_RESET = 1'b1;
    wait_sys(1'b0, 60, n);
    chk("release_fall", 32'(n), 15);
    chk("release_ready", 32'(bus.SYS_READY), 1);
    tick(1);
    chk("release_ready_drop", 32'(bus.SYS_READY), 0);
    chk("press_count", 32'(bus.RESET_COUNT), 1);

    // Re-press lands 3 cycles into STRETCH.
    por();
    bus.EXT_RESET = 1'b0;
    tick(20);
    bus.EXT_RESET = 1'b1;
    rdy    = 0;
    sr_and = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 4) bus.EXT_RESET = 1'b0;
      tick(1);
      rdy    = rdy + int'(bus.SYS_READY);
      sr_and = sr_and & bus.SYS_RESET;
    end
    chk("repress_no_ready", 32'(rdy), 0);
    chk("repress_held", 32'(sr_and), 1);
    chk("repress_state", 32'(u_dut.state), 32'(EXT_HOLD));
    bus.EXT_RESET = 1'b1;
    wait_sys(1'b0, 60, n);
    chk("repress_release", 32'(n), 15);
    chk("repress_count", 32'(bus.RESET_COUNT), 2);

    // 2-bit counter saturates at 3.
    for (int k = 0; k < 5; k++) begin
      bus2.EXT_RESET = 1'b0;
      tick(10);
      bus2.EXT_RESET = 1'b1;
      tick(8);
      chk($sformatf("sat_%0d", k), 32'(bus2.RESET_COUNT),
          (k < 2) ? 32'(k + 1) : 32'd3);
    end

    // RESET during EXT_HOLD with count 2 and pin held low.
    por();
    bus.EXT_RESET = 1'b0;
    tick(20);
    bus.EXT_RESET = 1'b1;
    tick(4);
    bus.EXT_RESET = 1'b0;
    tick(10);
    chk("mid_pre_state", 32'(u_dut.state), 32'(EXT_HOLD));
    chk("mid_pre_count", 32'(bus.RESET_COUNT), 2);
    #1 rst = 1'b1;
    #1;
    chk("mid_sys_reset", 32'(bus.SYS_RESET), 1);
    chk("mid_count", 32'(bus.RESET_COUNT), 0);
    chk("mid_ready", 32'(bus.SYS_READY), 0);
    tick(2);
    rst = 1'b0;
    chk("mid_rel_state", 32'(u_dut.state), 32'(STRETCH));
    chk("mid_rel_level", 32'(bus.EXT_LEVEL), 1);
    tick(7);
    chk("mid_hold_state", 32'(u_dut.state), 32'(EXT_HOLD));
    chk("mid_hold_count", 32'(bus.RESET_COUNT), 1);
    chk("mid_hold_level", 32'(bus.EXT_LEVEL), 0);
    chk("mid_hold_sys", 32'(bus.SYS_RESET), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
